// File: rtl/dwc_upconv_wr_cmd_split.sv
// ---------------------------------------------------------------------------
// dwc_upconv_wr_cmd_split
//
// Sits directly behind the up-converter A-channel pre-calc register slice.
// Each accepted master AW/AR command is turned into one or two entries for
// the up-converter command FIFO, expressed in slave (DATA_WIDTH_OUT) beats.
// Unaligned WRAP bursts (wrap_tx_pre=1) are split into two INCR pieces at
// the wrap boundary; every other command yields a single entry.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   MASTER_A*                command handshake and fields from pre-calc stage
//   *_pre                    pre-calculated split/length helpers
//   cmd_fifo_full            FIFO cannot accept a write this cycle
//   cmd_wr_en                FIFO write strobe
//   cmd_*                    FIFO entry fields (all zero while idle)
// ---------------------------------------------------------------------------
module dwc_upconv_wr_cmd_split #(
  parameter int DATA_WIDTH_OUT = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int SIDE_WIDTH     = 22
) (
  input  logic                  clk,
  input  logic                  rst,
  // command from pre-calc stage
  input  logic                  MASTER_AVALID_in,
  output logic                  MASTER_AREADY_out,
  input  logic [ADDR_WIDTH-1:0] MASTER_AADDR_in,
  input  logic [7:0]            MASTER_ALEN_in,
  input  logic [2:0]            MASTER_ASIZE_in,
  input  logic [1:0]            MASTER_ABURST_in,
  input  logic [ID_WIDTH-1:0]   MASTER_AID_in,
  input  logic [SIDE_WIDTH-1:0] MASTER_ASIDE_in,
  // pre-calculated fields
  input  logic [7:0]            alen_wrap_pre,
  input  logic [7:0]            alen_sec_wrap_pre,
  input  logic [4:0]            to_boundary_master_pre,
  input  logic [9:0]            mask_wrap_addr_pre,
  input  logic [2:0]            sizeDiff_pre,
  input  logic [5:0]            len_offset_pre,
  input  logic                  wrap_tx_pre,
  input  logic                  fixed_flag_comb_pre,
  // command FIFO write side
  input  logic                  cmd_fifo_full,
  output logic                  cmd_wr_en,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [7:0]            cmd_len,
  output logic [2:0]            cmd_size,
  output logic [1:0]            cmd_burst,
  output logic [7:0]            cmd_mst_len,
  output logic [5:0]            cmd_offset,
  output logic                  cmd_fixed,
  output logic                  cmd_last_piece,
  output logic [ID_WIDTH-1:0]   cmd_id,
  output logic [SIDE_WIDTH-1:0] cmd_side
);

  localparam logic [2:0] SLV_SIZE    = 3'($clog2(DATA_WIDTH_OUT / 8));
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE1 = 2'd1,
    ISSUE2 = 2'd2
  } state_t;

  state_t state, state_nxt;

  // holding registers for the accepted command
  logic [ADDR_WIDTH-1:0] h_addr;
  logic [7:0]            h_alen;
  logic [2:0]            h_asize;
  logic [1:0]            h_burst;
  logic [ID_WIDTH-1:0]   h_id;
  logic [SIDE_WIDTH-1:0] h_side;
  logic [7:0]            h_alen_wrap;
  logic [7:0]            h_alen_sec;
  logic [4:0]            h_to_boundary;
  logic [9:0]            h_mask;
  logic [2:0]            h_size_diff;
  logic [5:0]            h_offset;
  logic                  h_wrap_tx;
  logic                  h_fixed;

  logic accept;
  logic written;
  logic split;

  logic [8:0]            len_sum;
  logic [ADDR_WIDTH-1:0] mask_ext;
  logic [ADDR_WIDTH-1:0] piece2_addr;
  logic [7:0]            piece1_mst_len;
  logic [7:0]            piece2_mst_len;

  assign MASTER_AREADY_out = (state == IDLE);
  assign accept            = MASTER_AVALID_in & MASTER_AREADY_out;
  assign cmd_wr_en         = (state != IDLE) & ~cmd_fifo_full;
  assign written           = cmd_wr_en;
  // FIXED bursts never split, even if the wrap flag were set upstream
  assign split             = h_wrap_tx & ~h_fixed;

  // ---------------------------------------------------------------------
  // state register and command holding registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      h_addr        <= '0;
      h_alen        <= '0;
      h_asize       <= '0;
      h_burst       <= '0;
      h_id          <= '0;
      h_side        <= '0;
      h_alen_wrap   <= '0;
      h_alen_sec    <= '0;
      h_to_boundary <= '0;
      h_mask        <= '0;
      h_size_diff   <= '0;
      h_offset      <= '0;
      h_wrap_tx     <= 1'b0;
      h_fixed       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        h_addr        <= MASTER_AADDR_in;
        h_alen        <= MASTER_ALEN_in;
        h_asize       <= MASTER_ASIZE_in;
        h_burst       <= MASTER_ABURST_in;
        h_id          <= MASTER_AID_in;
        h_side        <= MASTER_ASIDE_in;
        h_alen_wrap   <= alen_wrap_pre;
        h_alen_sec    <= alen_sec_wrap_pre;
        h_to_boundary <= to_boundary_master_pre;
        h_mask        <= mask_wrap_addr_pre;
        h_size_diff   <= sizeDiff_pre;
        h_offset      <= len_offset_pre;
        h_wrap_tx     <= wrap_tx_pre;
        h_fixed       <= fixed_flag_comb_pre;
      end
    end
  end

  // ---------------------------------------------------------------------
  // next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)  state_nxt = ISSUE1;
      ISSUE1:  if (written) state_nxt = split ? ISSUE2 : IDLE;
      ISSUE2:  if (written) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // per-piece field arithmetic
  // ---------------------------------------------------------------------
  always_comb begin
    len_sum        = {1'b0, h_alen} + {3'b000, h_offset};
    mask_ext       = '0;
    mask_ext[9:0]  = h_mask;
    // second piece restarts at the bottom of the wrap container
    piece2_addr    = h_addr & ~mask_ext;
    piece1_mst_len = {3'b000, h_to_boundary} - 8'd1;
    piece2_mst_len = h_alen - {3'b000, h_to_boundary};
  end

  // ---------------------------------------------------------------------
  // FIFO entry; forced to zero while idle so stale commands never leak
  // ---------------------------------------------------------------------
  always_comb begin
    cmd_addr       = '0;
    cmd_len        = '0;
    cmd_size       = '0;
    cmd_burst      = '0;
    cmd_mst_len    = '0;
    cmd_offset     = '0;
    cmd_fixed      = 1'b0;
    cmd_last_piece = 1'b0;
    cmd_id         = '0;
    cmd_side       = '0;
    if (state != IDLE) begin
      cmd_id   = h_id;
      cmd_side = h_side;
      if (h_fixed) begin
        cmd_addr       = h_addr;
        cmd_len        = h_alen;
        cmd_size       = h_asize;
        cmd_burst      = BURST_FIXED;
        cmd_mst_len    = h_alen;
        cmd_offset     = h_offset;
        cmd_fixed      = 1'b1;
        cmd_last_piece = 1'b1;
      end else if (split && state == ISSUE1) begin
        cmd_addr       = h_addr;
        cmd_len        = h_alen_wrap;
        cmd_size       = SLV_SIZE;
        cmd_burst      = BURST_INCR;
        cmd_mst_len    = piece1_mst_len;
        cmd_offset     = h_offset;
        cmd_last_piece = 1'b0;
      end else if (state == ISSUE2) begin
        cmd_addr       = piece2_addr;
        cmd_len        = h_alen_sec;
        cmd_size       = SLV_SIZE;
        cmd_burst      = BURST_INCR;
        cmd_mst_len    = piece2_mst_len;
        cmd_offset     = '0;
        cmd_last_piece = 1'b1;
      end else begin
        cmd_addr       = h_addr;
        cmd_len        = 8'(len_sum >> h_size_diff);
        cmd_size       = SLV_SIZE;
        cmd_burst      = h_burst;
        cmd_mst_len    = h_alen;
        cmd_offset     = h_offset;
        cmd_last_piece = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dwc_upconv_wr_cmd_split.sv
// ---------------------------------------------------------------------------
// tb_dwc_upconv_wr_cmd_split
//
// Directed bench for dwc_upconv_wr_cmd_split with DATA_WIDTH_OUT=64.
// Inputs change #1 after a rising edge; outputs are checked at that point.
// ---------------------------------------------------------------------------
module tb_dwc_upconv_wr_cmd_split;

  localparam int DW  = 64;
  localparam int AW  = 32;
  localparam int IDW = 4;
  localparam int SW  = 22;

  logic          clk = 1'b0;
  logic          rst;
  logic          avalid;
  logic          aready;
  logic [AW-1:0] aaddr;
  logic [7:0]    alen;
  logic [2:0]    asize;
  logic [1:0]    aburst;
  logic [IDW-1:0] aid;
  logic [SW-1:0] aside;
  logic [7:0]    alen_wrap;
  logic [7:0]    alen_sec;
  logic [4:0]    to_boundary;
  logic [9:0]    mask_wrap;
  logic [2:0]    size_diff;
  logic [5:0]    len_offset;
  logic          wrap_tx;
  logic          fixed_flag;
  logic          fifo_full;
  logic          wr_en;
  logic [AW-1:0] c_addr;
  logic [7:0]    c_len;
  logic [2:0]    c_size;
  logic [1:0]    c_burst;
  logic [7:0]    c_mst_len;
  logic [5:0]    c_offset;
  logic          c_fixed;
  logic          c_last;
  logic [IDW-1:0] c_id;
  logic [SW-1:0] c_side;

  int n_cmp = 0;
  int n_err = 0;
  logic [AW-1:0] wr_addr_q[$];
  logic [7:0]    wr_len_q[$];

  always #5 clk = ~clk;

  dwc_upconv_wr_cmd_split #(
    .DATA_WIDTH_OUT(DW),
    .ADDR_WIDTH    (AW),
    .ID_WIDTH      (IDW),
    .SIDE_WIDTH    (SW)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .MASTER_AVALID_in       (avalid),
    .MASTER_AREADY_out      (aready),
    .MASTER_AADDR_in        (aaddr),
    .MASTER_ALEN_in         (alen),
    .MASTER_ASIZE_in        (asize),
    .MASTER_ABURST_in       (aburst),
    .MASTER_AID_in          (aid),
    .MASTER_ASIDE_in        (aside),
    .alen_wrap_pre          (alen_wrap),
    .alen_sec_wrap_pre      (alen_sec),
    .to_boundary_master_pre (to_boundary),
    .mask_wrap_addr_pre     (mask_wrap),
    .sizeDiff_pre           (size_diff),
    .len_offset_pre         (len_offset),
    .wrap_tx_pre            (wrap_tx),
    .fixed_flag_comb_pre    (fixed_flag),
    .cmd_fifo_full          (fifo_full),
    .cmd_wr_en              (wr_en),
    .cmd_addr               (c_addr),
    .cmd_len                (c_len),
    .cmd_size               (c_size),
    .cmd_burst              (c_burst),
    .cmd_mst_len            (c_mst_len),
    .cmd_offset             (c_offset),
    .cmd_fixed              (c_fixed),
    .cmd_last_piece         (c_last),
    .cmd_id                 (c_id),
    .cmd_side               (c_side)
  );

  // FIFO-side log of every write strobe outside reset
  always @(posedge clk) begin
    if (!rst && wr_en) begin
      wr_addr_q.push_back(c_addr);
      wr_len_q.push_back(c_len);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [AW-1:0] a, input logic [7:0] l, input logic [2:0] s,
                         input logic [1:0] b, input logic [5:0] off, input logic [2:0] sd,
                         input logic wt, input logic fx);
    aaddr = a; alen = l; asize = s; aburst = b;
    len_offset = off; size_diff = sd; wrap_tx = wt; fixed_flag = fx;
  endtask

  initial begin
    rst = 1'b1; avalid = 1'b0; fifo_full = 1'b0;
    aid = 4'hA; aside = 22'h2ABCDE;
    alen_wrap = '0; alen_sec = '0; to_boundary = '0; mask_wrap = '0;
    set_cmd(32'h0, 8'd0, 3'd0, 2'b01, 6'd0, 3'd0, 1'b0, 1'b0);
    tick(); tick();

    // reset state
    chk("rst_aready", 64'(aready), 64'd1);
    chk("rst_wr_en",  64'(wr_en),  64'd0);
    chk("rst_addr",   64'(c_addr), 64'd0);
    chk("rst_size",   64'(c_size), 64'd0);
    chk("rst_last",   64'(c_last), 64'd0);
    rst = 1'b0;
    tick();

    // single-piece INCR
    set_cmd(32'h04, 8'd3, 3'd2, 2'b01, 6'd1, 3'd1, 1'b0, 1'b0);
    avalid = 1'b1;
    tick();                             // accept at edge N
    avalid = 1'b0;
    chk("incr_wr_en",  64'(wr_en),     64'd1);
    chk("incr_aready", 64'(aready),    64'd0);
    chk("incr_addr",   64'(c_addr),    64'h04);
    chk("incr_len",    64'(c_len),     64'd2);
    chk("incr_size",   64'(c_size),    64'd3);
    chk("incr_burst",  64'(c_burst),   64'd1);
    chk("incr_mst",    64'(c_mst_len), 64'd3);
    chk("incr_off",    64'(c_offset),  64'd1);
    chk("incr_last",   64'(c_last),    64'd1);
    chk("incr_id",     64'(c_id),      64'hA);
    chk("incr_side",   64'(c_side),    64'h2ABCDE);
    tick();
    chk("incr_idle_wr", 64'(wr_en),  64'd0);
    chk("incr_idle_rd", 64'(aready), 64'd1);
    chk("incr_idle_len", 64'(c_len), 64'd0);

    // split WRAP, spec vector
    set_cmd(32'h08, 8'd3, 3'd2, 2'b10, 6'd1, 3'd1, 1'b1, 1'b0);
    to_boundary = 5'd2; alen_wrap = 8'd0; alen_sec = 8'd0; mask_wrap = 10'h00F;
    avalid = 1'b1;
    tick();
    avalid = 1'b0;
    chk("wr1_wr_en", 64'(wr_en),     64'd1);
    chk("wr1_addr",  64'(c_addr),    64'h08);
    chk("wr1_len",   64'(c_len),     64'd0);
    chk("wr1_mst",   64'(c_mst_len), 64'd1);
    chk("wr1_last",  64'(c_last),    64'd0);
    chk("wr1_burst", 64'(c_burst),   64'd1);
    chk("wr1_off",   64'(c_offset),  64'd1);
    tick();
    chk("wr2_wr_en", 64'(wr_en),     64'd1);
    chk("wr2_addr",  64'(c_addr),    64'h00);
    chk("wr2_len",   64'(c_len),     64'd0);
    chk("wr2_mst",   64'(c_mst_len), 64'd1);
    chk("wr2_last",  64'(c_last),    64'd1);
    chk("wr2_off",   64'(c_offset),  64'd0);
    chk("wr2_aready", 64'(aready),   64'd0);
    tick();
    chk("wr_idle_rd", 64'(aready), 64'd1);

    // split WRAP with distinct piece values and upper address bits
    set_cmd(32'h1234_0018, 8'd7, 3'd2, 2'b10, 6'd0, 3'd1, 1'b1, 1'b0);
    to_boundary = 5'd3; alen_wrap = 8'd1; alen_sec = 8'd2; mask_wrap = 10'h01F;
    aid = 4'h5; aside = 22'h13579B;
    avalid = 1'b1;
    tick();
    avalid = 1'b0;
    chk("wb1_addr", 64'(c_addr),    64'h1234_0018);
    chk("wb1_len",  64'(c_len),     64'd1);
    chk("wb1_mst",  64'(c_mst_len), 64'd2);
    chk("wb1_id",   64'(c_id),      64'h5);
    tick();
    chk("wb2_addr", 64'(c_addr),    64'h1234_0000);
    chk("wb2_len",  64'(c_len),     64'd2);
    chk("wb2_mst",  64'(c_mst_len), 64'd4);
    chk("wb2_size", 64'(c_size),    64'd3);
    chk("wb2_id",   64'(c_id),      64'h5);
    chk("wb2_side", 64'(c_side),    64'h13579B);
    tick();

    // FIXED
    set_cmd(32'h02, 8'd7, 3'd1, 2'b00, 6'd0, 3'd2, 1'b0, 1'b1);
    avalid = 1'b1;
    tick();
    avalid = 1'b0;
    chk("fix_wr_en", 64'(wr_en),     64'd1);
    chk("fix_addr",  64'(c_addr),    64'h02);
    chk("fix_len",   64'(c_len),     64'd7);
    chk("fix_size",  64'(c_size),    64'd1);
    chk("fix_burst", 64'(c_burst),   64'd0);
    chk("fix_flag",  64'(c_fixed),   64'd1);
    chk("fix_mst",   64'(c_mst_len), 64'd7);
    chk("fix_last",  64'(c_last),    64'd1);
    tick();

    // FIFO full for 5 cycles after accept: (5+3)>>1 = 4
    set_cmd(32'h40, 8'd5, 3'd2, 2'b01, 6'd3, 3'd1, 1'b0, 1'b0);
    fifo_full = 1'b1;
    avalid = 1'b1;
    tick();
    avalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("full_wr_en",  64'(wr_en),  64'd0);
      chk("full_aready", 64'(aready), 64'd0);
      chk("full_len",    64'(c_len),  64'd4);
      chk("full_addr",   64'(c_addr), 64'h40);
      if (i < 4) tick();
    end
    fifo_full = 1'b0;
    #1;
    chk("full_rel_wr", 64'(wr_en), 64'd1);
    chk("full_rel_len", 64'(c_len), 64'd4);
    tick();
    chk("full_done_rd", 64'(aready), 64'd1);

    // reset while piece 2 is pending
    set_cmd(32'h08, 8'd3, 3'd2, 2'b10, 6'd1, 3'd1, 1'b1, 1'b0);
    to_boundary = 5'd2; alen_wrap = 8'd0; alen_sec = 8'd0; mask_wrap = 10'h00F;
    avalid = 1'b1;
    tick();
    avalid = 1'b0;
    tick();                             // piece 1 written, now in ISSUE2
    chk("rst2_pending", 64'(c_last), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_wr_en",  64'(wr_en),  64'd0);
    chk("rst2_aready", 64'(aready), 64'd1);
    chk("rst2_addr",   64'(c_addr), 64'd0);
    wr_addr_q.delete();
    wr_len_q.delete();
    tick(); tick();
    chk("rst2_no_wr", 64'(wr_addr_q.size()), 64'd0);

    // back-to-back INCR commands
    set_cmd(32'h100, 8'd1, 3'd3, 2'b01, 6'd0, 3'd0, 1'b0, 1'b0);
    avalid = 1'b1;
    chk("b2b_rd0", 64'(aready), 64'd1);
    tick();
    chk("b2b_rd1", 64'(aready), 64'd0);
    set_cmd(32'h200, 8'd2, 3'd3, 2'b01, 6'd0, 3'd0, 1'b0, 1'b0);
    tick();
    chk("b2b_rd2", 64'(aready), 64'd1);
    tick();
    chk("b2b_rd3", 64'(aready), 64'd0);
    set_cmd(32'h300, 8'd3, 3'd3, 2'b01, 6'd0, 3'd0, 1'b0, 1'b0);
    tick();
    chk("b2b_rd4", 64'(aready), 64'd1);
    tick();
    avalid = 1'b0;
    tick();
    chk("b2b_count", 64'(wr_addr_q.size()), 64'd3);
    if (wr_addr_q.size() == 3) begin
      chk("b2b_a0", 64'(wr_addr_q[0]), 64'h100);
      chk("b2b_a1", 64'(wr_addr_q[1]), 64'h200);
      chk("b2b_a2", 64'(wr_addr_q[2]), 64'h300);
      chk("b2b_l2", 64'(wr_len_q[2]),  64'd3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
